fadd_axis_resp: RTL

FADD_AXIS_RESP -- requirements
Module: fadd_axis_resp

---
 rtl/fadd_axis_resp.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fadd_axis_resp.sv
// Single-precision adder with independent AXI-Stream operand slots and a registered result channel.
// Flush-to-zero on subnormals, round-to-nearest-even, one cycle per ALIGN/ADD/NORM/ROUND stage.
module fadd_axis_resp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    output logic [31:0] m_axis_result_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

    state_t      r_state, w_nextState;
    logic        r_aFull, r_bFull, r_aReady, r_bReady, r_valid;
    logic [31:0] r_a, r_b, r_result;
    logic        w_aFire, w_bFire, w_resultFire, w_aFullNext, w_bFullNext;

    assign w_aFire      = s_axis_a_tvalid & r_aReady;
    assign w_bFire      = s_axis_b_tvalid & r_bReady;
    assign w_resultFire = r_valid & m_axis_result_tready;

    always_comb begin
        w_nextState = r_state;
        w_aFullNext = r_aFull | w_aFire;
        w_bFullNext = r_bFull | w_bFire;
        case (r_state)
            IDLE:    if (w_aFullNext && w_bFullNext) w_nextState = ALIGN;
            ALIGN:   w_nextState = ADD;
            ADD:     w_nextState = NORM;
            NORM:    w_nextState = ROUND;
            ROUND:   w_nextState = OUT;
            OUT: begin
                if (w_resultFire) begin
                    w_nextState = IDLE;
                    w_aFullNext = 1'b0;
                    w_bFullNext = 1'b0;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    logic [31:0] w_result;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_aFull  <= 1'b0;
            r_bFull  <= 1'b0;
            r_aReady <= 1'b0;
            r_bReady <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_state  <= w_nextState;
            r_aFull  <= w_aFullNext;
            r_bFull  <= w_bFullNext;
            r_aReady <= (w_nextState == IDLE) && !w_aFullNext;
            r_bReady <= (w_nextState == IDLE) && !w_bFullNext;
            r_valid  <= (w_nextState == OUT);
            if (r_state == ROUND) r_result <= w_result;
        end
    end

    assign s_axis_a_tready      = r_aReady;
    assign s_axis_b_tready      = r_bReady;
    assign m_axis_result_tvalid = r_valid;
    assign m_axis_result_tdata  = r_result;

    // Unpack, order by magnitude and align; subnormals collapse to zero magnitude here.
    logic [7:0]  w_aExp, w_bExp, w_expDiff;
    logic        w_aNan, w_bNan, w_aInf, w_bInf, w_swap;
    logic [30:0] w_aMag, w_bMag, w_bigMag, w_smallMag;
    logic [23:0] w_bigSig, w_smallSig;
    logic [4:0]  w_shiftAmt;
    logic [51:0] w_wide;
    logic [26:0] w_sigY;
    logic        w_special;
    logic [31:0] w_specialVal;

    assign w_aExp     = r_a[30:23];
    assign w_bExp     = r_b[30:23];
    assign w_aNan     = (w_aExp == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_bNan     = (w_bExp == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_aInf     = (w_aExp == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_bInf     = (w_bExp == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_aMag     = (w_aExp == 8'd0) ? 31'd0 : r_a[30:0];
    assign w_bMag     = (w_bExp == 8'd0) ? 31'd0 : r_b[30:0];
    assign w_swap     = w_bMag > w_aMag;
    assign w_bigMag   = w_swap ? w_bMag : w_aMag;
    assign w_smallMag = w_swap ? w_aMag : w_bMag;
    assign w_bigSig   = (w_bigMag[30:23] != 8'd0) ? {1'b1, w_bigMag[22:0]} : 24'd0;
    assign w_smallSig = (w_smallMag[30:23] != 8'd0) ? {1'b1, w_smallMag[22:0]} : 24'd0;
    assign w_expDiff  = w_bigMag[30:23] - w_smallMag[30:23];
    assign w_shiftAmt = (w_expDiff > 8'd26) ? 5'd26 : w_expDiff[4:0];
    assign w_wide     = {w_smallSig, 28'd0} >> w_shiftAmt;
    assign w_sigY     = {w_wide[51:26], |w_wide[25:0]};

    always_comb begin
        w_special    = 1'b0;
        w_specialVal = 32'h7FC00000;
        if (w_aNan || w_bNan || (w_aInf && w_bInf && (r_a[31] != r_b[31]))) begin
            w_special = 1'b1;
        end else if (w_aInf) begin
            w_special    = 1'b1;
            w_specialVal = r_a;
        end else if (w_bInf) begin
            w_special    = 1'b1;
            w_specialVal = r_b;
        end
    end

    logic [26:0]        r_sigX, r_sigY, r_norm, w_norm;
    logic [7:0]         r_expBig;
    logic               r_signBig, r_sub, r_zeroSign, r_special, r_isZero;
    logic [31:0]        r_specialVal;
    logic [27:0]        r_sum, w_sum;
    logic signed [9:0]  r_normExp, w_normExp, w_finalExp;
    logic [4:0]         w_lead, w_lshift;

    assign w_sum = r_sub ? ({1'b0, r_sigX} - {1'b0, r_sigY}) : ({1'b0, r_sigX} + {1'b0, r_sigY});

    always_comb begin
        w_lead = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) w_lead = 5'(i);
        end
        w_lshift = 5'd26 - w_lead;
        if (r_sum[27]) begin
            w_norm    = {r_sum[27:2], r_sum[1] | r_sum[0]};
            w_normExp = $signed({2'b00, r_expBig}) + 10'sd1;
        end else begin
            w_norm    = r_sum[26:0] << w_lshift;
            w_normExp = $signed({2'b00, r_expBig}) - $signed({5'd0, w_lshift});
        end
    end

    // Stage registers free-run; each stage's inputs are stable by the time its state is active.
    always_ff @(posedge clk) begin
        if (w_aFire) r_a <= s_axis_a_tdata;
        if (w_bFire) r_b <= s_axis_b_tdata;
        r_sigX       <= {w_bigSig, 3'b000};
        r_sigY       <= w_sigY;
        r_expBig     <= w_bigMag[30:23];
        r_signBig    <= w_swap ? r_b[31] : r_a[31];
        r_sub        <= r_a[31] ^ r_b[31];
        r_zeroSign   <= r_a[31] & r_b[31];
        r_special    <= w_special;
        r_specialVal <= w_specialVal;
        r_sum        <= w_sum;
        r_norm       <= w_norm;
        r_normExp    <= w_normExp;
        r_isZero     <= (r_sum == 28'd0);
    end

    logic        w_inc;
    logic [24:0] w_mantR;
    logic [22:0] w_finalFrac;

    assign w_inc       = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    assign w_mantR     = {1'b0, r_norm[26:3]} + {24'd0, w_inc};
    assign w_finalExp  = w_mantR[24] ? (r_normExp + 10'sd1) : r_normExp;
    assign w_finalFrac = w_mantR[24] ? w_mantR[23:1] : w_mantR[22:0];

    always_comb begin
        w_result = {r_signBig, w_finalExp[7:0], w_finalFrac};
        if (r_special)                     w_result = r_specialVal;
        else if (r_isZero)                 w_result = {r_zeroSign, 31'd0};
        else if (w_finalExp <= 10'sd0)     w_result = {r_signBig, 31'd0};
        else if (w_finalExp >= 10'sd255)   w_result = {r_signBig, 8'hFF, 23'd0};
    end

endmodule
